// File: rtl/read_burst_tracker.sv
// rtl/read_burst_tracker.sv - READ tracking FIFO, CAS-timed burst capture and single-entry line output
// Define READ_BURST_CWF_EN for critical-word-first slot ordering; default stores beats in arrival order.
module read_burst_tracker #(
  parameter int DEPTH       = 32,
  parameter int CAS_LATENCY = 22,
  parameter int BURST_LEN   = 8,
  parameter int BEAT_BITS   = 64,
  parameter int PADDR_BITS  = 19,
  parameter int COL_BITS    = 4
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           issue_valid_in,
  input  logic [PADDR_BITS-1:0]          issue_paddr_in,
  input  logic [COL_BITS-1:0]            issue_col_in,
  output logic                           issue_ready_out,
  input  logic [BEAT_BITS-1:0]           dq_in,
  output logic                           capturing_out,
  output logic                           line_valid_out,
  input  logic                           line_ready_in,
  output logic [BURST_LEN*BEAT_BITS-1:0] line_out,
  output logic [PADDR_BITS-1:0]          line_paddr_out,
  output logic [$clog2(DEPTH):0]         outstanding_out,
  output logic                           overflow_err_out
);

  localparam int PTR_BITS  = $clog2(DEPTH);
  localparam int CNT_BITS  = PTR_BITS + 1;
  localparam int SLOT_BITS = $clog2(BURST_LEN);
  localparam int LINE_BITS = BURST_LEN * BEAT_BITS;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  localparam logic [31:0]          CAS_DIFF   = 32'(CAS_LATENCY);
  localparam logic [SLOT_BITS-1:0] LAST_SLOT  = SLOT_BITS'(BURST_LEN - 1);
  localparam logic [CNT_BITS-1:0]  FULL_COUNT = CNT_BITS'(DEPTH);

  logic [PADDR_BITS-1:0] paddr_mem [DEPTH];
  logic [31:0]           stamp_mem [DEPTH];

  logic [31:0]           cycle;
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;
  logic [PTR_BITS-1:0]   rd_next;
  logic [CNT_BITS-1:0]   count;
  logic [SLOT_BITS-1:0]  spacing;
  logic [SLOT_BITS-1:0]  beat;
  logic [SLOT_BITS-1:0]  base;
  logic [SLOT_BITS-1:0]  slot;
  logic [0:0]            state;
  logic [LINE_BITS-1:0]  assembly;
  logic [LINE_BITS-1:0]  assembly_next;
  logic [LINE_BITS-1:0]  line_reg;
  logic [PADDR_BITS-1:0] line_paddr;
  logic                  line_valid;
  logic                  overflow;
  logic                  accept;
  logic                  head_due;
  logic                  next_due;
  logic                  last_beat;
  logic                  unused_col;

  assign unused_col = ^issue_col_in;

  assign rd_next         = rd_ptr + PTR_BITS'(1);
  assign issue_ready_out = (count != FULL_COUNT) && (spacing == '0);
  assign accept          = issue_valid_in && issue_ready_out;

  // Evaluated one edge early so the registered capturing flag lines up with the first sampled beat.
  assign head_due  = (count != '0) &&
                     ((cycle + 32'd1 - stamp_mem[rd_ptr]) == CAS_DIFF);
  assign next_due  = (count > CNT_BITS'(1)) &&
                     ((cycle + 32'd1 - stamp_mem[rd_next]) == CAS_DIFF);
  assign last_beat = (state == ST_BURST) && (beat == LAST_SLOT);
  assign slot      = base + beat;

  always_comb begin
    assembly_next = assembly;
    assembly_next[int'(slot)*BEAT_BITS +: BEAT_BITS] = dq_in;
  end

  always_ff @(posedge clk_in) begin
    if (accept) begin
      paddr_mem[wr_ptr] <= issue_paddr_in;
      stamp_mem[wr_ptr] <= cycle;
    end
  end

`ifdef READ_BURST_CWF_EN
  logic [SLOT_BITS-1:0] col_mem [DEPTH];

  always_ff @(posedge clk_in) begin
    if (accept) begin
      col_mem[wr_ptr] <= issue_col_in[SLOT_BITS-1:0];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      base <= '0;
    end else if ((state == ST_IDLE) && head_due) begin
      base <= col_mem[rd_ptr];
    end else if (last_beat && next_due) begin
      base <= col_mem[rd_next];
    end
  end
`else
  assign base = '0;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cycle      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      spacing    <= '0;
      beat       <= '0;
      state      <= ST_IDLE;
      assembly   <= '0;
      line_reg   <= '0;
      line_paddr <= '0;
      line_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cycle <= cycle + 32'd1;

      if (accept) begin
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      end
      if (last_beat) begin
        rd_ptr <= rd_next;
      end
      if (accept && !last_beat) begin
        count <= count + CNT_BITS'(1);
      end else if (!accept && last_beat) begin
        count <= count - CNT_BITS'(1);
      end

      // Holding off issue for BURST_LEN-1 cycles keeps bursts on the data bus from overlapping.
      if (accept) begin
        spacing <= LAST_SLOT;
      end else if (spacing != '0) begin
        spacing <= spacing - SLOT_BITS'(1);
      end

      case (state)
        ST_IDLE: begin
          if (head_due) begin
            state <= ST_BURST;
            beat  <= '0;
          end
        end
        default: begin
          assembly <= assembly_next;
          beat     <= beat + SLOT_BITS'(1);
          if (last_beat && !next_due) begin
            state <= ST_IDLE;
          end
        end
      endcase

      if (last_beat) begin
        if (!line_valid || line_ready_in) begin
          line_reg   <= assembly_next;
          line_paddr <= paddr_mem[rd_ptr];
          line_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (line_ready_in) begin
        line_valid <= 1'b0;
      end
    end
  end

  assign capturing_out    = (state == ST_BURST);
  assign line_valid_out   = line_valid;
  assign line_out         = line_reg;
  assign line_paddr_out   = line_paddr;
  assign outstanding_out  = count;
  assign overflow_err_out = overflow;

endmodule
